plot_sink: RTL and testbench
============================

PLOT_SINK -- requirements
Module: plot_sink

Interface
REQ-001 Parameter WIDTH, default 160, screen width in pixels; also the row stride for address generation.
REQ-002 Parameter HEIGHT, default 120, screen height in pixels.
REQ-003 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 x  input  8  pixel column from the plot source.
REQ-007 y  input  7  pixel row from the plot source.
REQ-008 colour  input  3  pixel colour.
REQ-009 plot  input  1  write-enable from the plot source; one pixel per high cycle; no back-pressure.
REQ-010 clr  input  1  synchronous clear of overflow and drop_count.
REQ-011 fb_addr  output  15  framebuffer word address.
REQ-012 fb_data  output  3  framebuffer colour data.
REQ-013 fb_we  output  1  framebuffer write request.
REQ-014 fb_ready  input  1  framebuffer accepts the write this cycle.
REQ-015 full  output  1  FIFO holds DEPTH entries.
REQ-016 busy  output  1  FIFO non-empty or fb_we high.
REQ-017 overflow  output  1  sticky; a valid pixel was lost to a full FIFO.
REQ-018 drop_count  output  8  pixels discarded (clipped or overflowed), saturating.

Function
REQ-019 Accept: on an edge with plot=1, x<WIDTH, y<HEIGHT and full=0 before the edge, {x,y,colour} SHALL be pushed into the FIFO.
REQ-020 Clip: plot=1 with x>=WIDTH or y>=HEIGHT SHALL be discarded and drop_count incremented; overflow unchanged.
REQ-021 Overflow: plot=1 with an in-range pixel while full=1 SHALL be discarded, overflow set to 1 and drop_count incremented, even if a pop occurs on the same edge.
REQ-022 drop_count SHALL saturate at 255, never wrap to 0.
REQ-023 clr=1 SHALL zero overflow and drop_count on that edge; a drop on the same edge is lost (clr wins).
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy count 0..DEPTH; full = (count==DEPTH).
REQ-025 Output stage is a 2-state FSM: EMPTY (fb_we=0) and HOLD (fb_we=1, registered addr/data valid).
REQ-026 EMPTY -> HOLD when the FIFO is non-empty; the head entry is popped and registered on that edge.
REQ-027 HOLD with fb_ready=1: the transfer completes; reload from the FIFO head on the same edge (stay HOLD) if the FIFO is non-empty, else go to EMPTY.
REQ-028 HOLD with fb_ready=0: fb_addr, fb_data and fb_we SHALL hold stable.
REQ-029 fb_addr = y*WIDTH + x, computed in 15 bits; for WIDTH=160 implemented as (y<<7)+(y<<5)+x, no multiplier.
REQ-030 Latency: a pixel pushed into an idle block at edge N SHALL appear with fb_we=1 after edge N+1.
REQ-031 Throughput: with fb_ready held 1 and continuous in-range plots, one write per cycle, no loss, full never asserts.
REQ-032 Pixels SHALL reach the framebuffer in plot order, each exactly once.
REQ-033 Simultaneous push and pop on a non-full FIFO SHALL leave count unchanged.
REQ-034 busy = (count!=0) | fb_we, combinational from registered state.

Reset
REQ-035 resetn=0 SHALL immediately force fb_we=0, fb_addr=0, fb_data=0, full=0, busy=0, overflow=0, drop_count=0, FSM=EMPTY, FIFO pointers and count 0.
REQ-036 Reset during HOLD or with queued pixels SHALL discard them; no write completes after reset asserts.
REQ-037 After release, the first edge with plot=1 SHALL be accepted normally.

Verification
REQ-038 Single pixel: x=5, y=3, colour=4, plot 1 cycle, fb_ready=1 -> one fb_we pulse after the next edge with fb_addr=485, fb_data=4; busy then 0.
REQ-039 Clip: x=160,y=0 then x=0,y=120 -> no fb_we, drop_count=2, overflow=0.
REQ-040 Back-pressure: fb_ready=0, 10 in-range plots -> first in HOLD, 8 queued, full=1, 10th pixel dropped, overflow=1, drop_count=1; raise fb_ready -> 9 writes in order, addr/data stable while stalled.
REQ-041 Streaming: 4x4 square at x=10,y=20 (16 consecutive plots), fb_ready=1 -> 16 writes addresses 3210..3213, 3370..3373, 3530..3533, 3690..3693, full never 1.
REQ-042 Saturation/clear: 300 clipped plots -> drop_count=255; clr=1 one cycle -> drop_count=0, overflow=0.
REQ-043 Reset mid-transfer: fb_ready=0, 3 pixels queued, pulse resetn low asynchronously between edges -> fb_we falls without a clock edge, no writes after release, busy=0.

Source files
------------

// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - pixel plot FIFO draining into a framebuffer write port
//
// Purpose: accepts one pixel per cycle from a plot source with no back-pressure,
// clips off-screen pixels, queues on-screen pixels in a small FIFO and presents
// them one at a time as registered framebuffer writes with a ready handshake.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   x, y, colour, plot  pixel from the plot source (plot = one pixel this cycle)
//   clr                 synchronous clear of overflow and drop_count
//   fb_addr, fb_data    registered framebuffer write address (y*WIDTH+x) and colour
//   fb_we, fb_ready     write request / framebuffer accepts this cycle
//   full, busy          FIFO full / any pixel still queued or being written
//   overflow            sticky: an on-screen pixel was lost to a full FIFO
//   drop_count          saturating count of clipped or overflowed pixels
module plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
  input  logic        clr,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH  = DEPTH[AW:0];
  localparam logic [8:0]  LP_WIDTH  = WIDTH[8:0];
  localparam logic [7:0]  LP_HEIGHT = HEIGHT[7:0];

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Each entry stores the already-computed word address plus colour.
  logic [17:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [14:0]   r_addr;
  logic [2:0]    r_data;
  logic          r_overflow;
  logic [7:0]    r_drop;

  logic          w_in_range;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_ovf;
  logic [14:0]   w_pix_addr;
  logic [17:0]   w_head;

  assign w_in_range = ({1'b0, x} < LP_WIDTH) && ({1'b0, y} < LP_HEIGHT);
  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  // Full is judged before the edge, so a pop on the same edge does not save
  // an incoming pixel.
  assign w_push     = plot & w_in_range & ~w_full;
  assign w_ovf      = plot & w_in_range & w_full;
  assign w_drop     = plot & (~w_in_range | w_full);
  assign w_head     = r_mem[r_rptr];

  generate
    if (WIDTH == 160) begin : g_addr_shift
      // 160 = 128 + 32
      assign w_pix_addr = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    end else begin : g_addr_mul
      localparam logic [14:0] LP_STRIDE = WIDTH[14:0];
      assign w_pix_addr = ({8'd0, y} * LP_STRIDE) + {7'd0, x};
    end
  endgenerate

  // Output stage: EMPTY loads the head as soon as one exists; HOLD keeps the
  // registered write stable until fb_ready, then reloads back-to-back.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (fb_ready) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_pop) begin
      r_addr <= w_head[17:3];
      r_data <= w_head[2:0];
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_pix_addr, colour};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // clr takes priority over a drop on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else if (clr) begin
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign fb_addr    = r_addr;
  assign fb_data    = r_data;
  assign fb_we      = (r_state == S_HOLD);
  assign full       = w_full;
  assign busy       = ~w_empty | fb_we;
  assign overflow   = r_overflow;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_plot_sink.sv
// tb/tb_plot_sink.sv - scoreboard testbench for plot_sink
module tb_plot_sink;

  localparam int SCR_W = 160;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        clr;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        full;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_count;

  int          n_total  = 0;
  int          n_bad    = 0;
  int          n_writes = 0;
  logic [17:0] q[$];

  plot_sink dut (
    .clk        (clk),
    .resetn     (resetn),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .clr        (clr),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .full       (full),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_px(input int px, input int py, input int pc, input bit accept);
    logic [14:0] a;
    logic [2:0]  c;
    x      = px[7:0];
    y      = py[6:0];
    colour = pc[2:0];
    plot   = 1'b1;
    if (accept) begin
      a = 15'(py * SCR_W + px);
      c = pc[2:0];
      q.push_back({a, c});
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_queue_empty", 32'(q.size()), 0);
    chk("drain_not_busy", {31'd0, busy}, 0);
  endtask

  // Write monitor: sampled on the falling edge, a write completes on the next
  // rising edge when fb_ready is high; while stalled it must show the head.
  always @(negedge clk) begin
    logic [17:0] e;
    if (resetn && fb_we) begin
      chk("write_expected", {31'd0, q.size() != 0}, 1);
      if (q.size() != 0) begin
        e = q[0];
        if (fb_ready) begin
          void'(q.pop_front());
          n_writes++;
          chk("wr_addr", {17'd0, fb_addr}, {17'd0, e[17:3]});
          chk("wr_data", {29'd0, fb_data}, {29'd0, e[2:0]});
        end else begin
          chk("stall_addr", {17'd0, fb_addr}, {17'd0, e[17:3]});
          chk("stall_data", {29'd0, fb_data}, {29'd0, e[2:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=%0d exp=%0d", n_total, 0);
    $fatal(1);
  end

  initial begin
    int  base;
    bit  saw_full;
    resetn   = 1'b0;
    x        = '0;
    y        = '0;
    colour   = '0;
    plot     = 1'b0;
    clr      = 1'b0;
    fb_ready = 1'b0;
    tick();
    tick();
    chk("rst_fb_we",    {31'd0, fb_we}, 0);
    chk("rst_fb_addr",  {17'd0, fb_addr}, 0);
    chk("rst_fb_data",  {29'd0, fb_data}, 0);
    chk("rst_full",     {31'd0, full}, 0);
    chk("rst_busy",     {31'd0, busy}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_drop",     {24'd0, drop_count}, 0);
    resetn = 1'b1;
    tick();

    // Single pixel with latency check
    fb_ready = 1'b1;
    base = n_writes;
    put_px(5, 3, 4, 1'b1);
    tick();
    plot = 1'b0;
    chk("lat_we_low_after_push", {31'd0, fb_we}, 0);
    chk("lat_busy_after_push", {31'd0, busy}, 1);
    tick();
    chk("lat_we_high", {31'd0, fb_we}, 1);
    chk("single_addr", {17'd0, fb_addr}, 485);
    chk("single_data", {29'd0, fb_data}, 4);
    tick();
    chk("single_we_done", {31'd0, fb_we}, 0);
    chk("single_busy_done", {31'd0, busy}, 0);
    drain(20);
    chk("single_writes", 32'(n_writes - base), 1);

    // Clipping
    base = n_writes;
    put_px(160, 0, 1, 1'b0);
    tick();
    put_px(0, 120, 2, 1'b0);
    tick();
    plot = 1'b0;
    tick();
    tick();
    chk("clip_drop", {24'd0, drop_count}, 2);
    chk("clip_overflow", {31'd0, overflow}, 0);
    chk("clip_writes", 32'(n_writes - base), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clip_clr_drop", {24'd0, drop_count}, 0);

    // Back-pressure: 1 in HOLD, 8 queued, 10th lost
    fb_ready = 1'b0;
    base = n_writes;
    for (int i = 0; i < 10; i++) begin
      put_px(i * 3 + 1, i + 2, i, i < 9);
      tick();
      if (i == 8) chk("bp_full_at_9", {31'd0, full}, 1);
    end
    plot = 1'b0;
    chk("bp_overflow", {31'd0, overflow}, 1);
    chk("bp_drop", {24'd0, drop_count}, 1);
    chk("bp_full", {31'd0, full}, 1);
    chk("bp_we", {31'd0, fb_we}, 1);
    tick();
    tick();
    tick();
    fb_ready = 1'b1;
    drain(40);
    chk("bp_writes", 32'(n_writes - base), 9);

    // Streaming 4x4 square: one write per cycle, never full
    base = n_writes;
    saw_full = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        put_px(10 + c, 20 + r, r + c, 1'b1);
        tick();
        if (full) saw_full = 1'b1;
      end
    end
    plot = 1'b0;
    tick();
    tick();
    chk("stream_drained_in_2", {31'd0, busy}, 0);
    chk("stream_never_full", {31'd0, saw_full}, 0);
    drain(20);
    chk("stream_writes", 32'(n_writes - base), 16);
    chk("sticky_overflow", {31'd0, overflow}, 1);
    chk("sticky_drop", {24'd0, drop_count}, 1);

    // Saturation and clear
    for (int i = 0; i < 300; i++) begin
      put_px(200, i % 100, 0, 1'b0);
      tick();
    end
    plot = 1'b0;
    chk("sat_drop", {24'd0, drop_count}, 255);
    put_px(200, 0, 0, 1'b0);
    clr = 1'b1;
    tick();
    plot = 1'b0;
    clr = 1'b0;
    chk("clr_wins_drop", {24'd0, drop_count}, 0);
    chk("clr_overflow", {31'd0, overflow}, 0);

    // Asynchronous reset mid-transfer
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put_px(40 + i, 50, 7 - i, 1'b1);
      tick();
    end
    plot = 1'b0;
    chk("mid_we_before_rst", {31'd0, fb_we}, 1);
    base = n_writes;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_we", {31'd0, fb_we}, 0);
    chk("async_busy", {31'd0, busy}, 0);
    chk("async_full", {31'd0, full}, 0);
    chk("async_addr", {17'd0, fb_addr}, 0);
    q.delete();
    fb_ready = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_writes", 32'(n_writes - base), 0);
    chk("post_rst_busy", {31'd0, busy}, 0);

    // First plot after release is accepted
    base = n_writes;
    put_px(159, 119, 3, 1'b1);
    tick();
    plot = 1'b0;
    drain(20);
    chk("post_rst_first", 32'(n_writes - base), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
